imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only while idle.
REQ-005 value  input  32  constant to encode as an ARM data-processing immediate.
REQ-006 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-007 done  output  1  one-cycle pulse marking that the result is valid.
REQ-008 found  output  1  1 = encodable; 0 = no rotate/imm8 pair exists.
REQ-009 shift_operand  output  12  {rotate_imm[3:0], imm8[7:0]}; decode rule is val = imm8 rotated right by 2*rotate_imm.

Function
REQ-010 SHALL implement three states: IDLE, SEARCH, DONE.
REQ-011 IDLE, start=1: latch value into an internal register, clear the rotation counter rot to 0, go to SEARCH.
REQ-012 IDLE, start=0: stay in IDLE.
REQ-013 Each SEARCH cycle SHALL test one candidate: t = latched value rotated left by 2*rot (5-bit amount, wrap-around); hit when t[31:8]==0.
REQ-014 On a hit: register found=1 and shift_operand={rot, t[7:0]}, then go to DONE.
REQ-015 No hit and rot==15: register found=0 and shift_operand=12'h000, then go to DONE.
REQ-016 No hit and rot<15: increment rot and stay in SEARCH.
REQ-017 Result SHALL be canonical: the smallest rot that hits.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-019 Latency, counting the start-accept cycle as cycle 0: done high in cycle r+2 on a hit at rot r; done high in cycle 17 on no hit.
REQ-020 start while busy or in DONE SHALL be ignored; no queuing and no effect on the latched value.
REQ-021 value changes after acceptance SHALL NOT affect the result.
REQ-022 found and shift_operand SHALL hold their last values until the next accepted start produces a result.
REQ-023 value=0 SHALL hit at rot 0: found=1, shift_operand=12'h000.
REQ-024 The rotator SHALL be combinational on the latched register; no multiplier and no barrel pipeline.

Reset
REQ-025 rst_n low, asynchronously: state=IDLE, rot=0, latched value=0, busy=0, done=0, found=0, shift_operand=0.
REQ-026 Reset asserted mid-SEARCH SHALL abort the search with no done pulse.
REQ-027 The first start after reset release SHALL be accepted normally.

Structure
REQ-028 State encoding (2 bits) and widths (ROT_W=4, IMM_W=8, WORD_W=32) SHALL live in the shared arm_defs package/include.
REQ-029 One sub-module, rotl32 (32-bit rotate-left by a 5-bit amount), SHALL hold the combinational rotate; all control stays in imm_encoder.

Verification
REQ-030 value=32'h000000FF, start pulse -> done in cycle 2, found=1, shift_operand=12'h0FF.
REQ-031 value=32'hFF000000 -> done in cycle 6, found=1, shift_operand=12'h4FF; value=32'hF000000F -> done in cycle 4, shift_operand=12'h2FF.
REQ-032 value=32'h00000104 -> done in cycle 17, found=1, shift_operand=12'hF41; value=32'h00000101 -> done in cycle 17, found=0, shift_operand=12'h000.
REQ-033 start re-pulsed and value changed during SEARCH for 32'hFF000000 -> result unchanged (12'h4FF); exactly one done pulse.
REQ-034 rst_n asserted in cycle 3 of a 32'h00000101 search -> all outputs 0 immediately, no done; a new start of 32'h0 after release -> done in cycle 2, found=1, shift_operand=12'h000.
REQ-035 Random values checked against a reference model: when found=1, decoding shift_operand (imm8 rotated right by 2*rotate_imm) equals value and rotate_imm is minimal; found=0 only when no rotate in 0..15 fits.

Source files
------------

// File: rtl/arm_defs_pkg.sv
// rtl/arm_defs_pkg.sv - shared widths and state encoding for the ARM immediate encoder
package arm_defs;

  localparam int ROT_W  = 4;
  localparam int IMM_W  = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rotl32.sv
// rtl/rotl32.sv - combinational 32-bit rotate-left by a 5-bit amount
module rotl32 (
  input  logic [31:0] data,
  input  logic [4:0]  amount,
  output logic [31:0] result
);

  logic [63:0] doubled;

  // Shifting the doubled word keeps amount 0 well defined (no shift by 32).
  assign doubled = {data, data} << amount;
  assign result  = doubled[63:32];

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - iterative search for the canonical ARM rotate/imm8 encoding of a constant
module imm_encoder
  import arm_defs::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WORD_W-1:0]       value,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [ROT_W+IMM_W-1:0]  shift_operand
);

  state_t            state;
  logic [WORD_W-1:0] word;
  logic [ROT_W-1:0]  rot;
  logic [WORD_W-1:0] cand;
  logic              hit;

  rotl32 u_rotl32 (
    .data   (word),
    .amount ({rot, 1'b0}),
    .result (cand)
  );

  assign hit = (cand[WORD_W-1:IMM_W] == '0);

  // Scanning rot upward means the first hit is the canonical (smallest) rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      word          <= '0;
      rot           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      shift_operand <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            word  <= value;
            rot   <= '0;
            busy  <= 1'b1;
            state <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (hit) begin
            found         <= 1'b1;
            shift_operand <= {rot, cand[IMM_W-1:0]};
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= ST_DONE;
          end else if (rot == {ROT_W{1'b1}}) begin
            found         <= 1'b0;
            shift_operand <= '0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= ST_DONE;
          end else begin
            rot <= rot + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - directed and model-checked bench for imm_encoder
module tb_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        found;
  logic [11:0] shift_operand;

  int n_vec;
  int n_bad;

  imm_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .value         (value),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .shift_operand (shift_operand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] v, input int amt);
    logic [63:0] d;
    d = {v, v} << amt;
    return d[63:32];
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] v, input int amt);
    logic [63:0] d;
    d = {v, v} >> amt;
    return d[31:0];
  endfunction

  // Reference: scan every rotation and keep the first that fits in 8 bits.
  task automatic model(input logic [31:0] v, output int lat, output logic f, output logic [11:0] so);
    logic [31:0] t;
    lat = 17; f = 1'b0; so = 12'h000;
    for (int r = 0; r < 16; r++) begin
      t = rol(v, 2 * r);
      if (t[31:8] == 24'h0) begin
        lat = r + 2; f = 1'b1; so = {r[3:0], t[7:0]};
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] v, input int exp_lat,
                         input logic exp_f, input logic [11:0] exp_so, input bit disturb);
    int lat;
    int pulses;
    logic [31:0] dec;
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_busy1"}, {31'b0, busy}, 32'd1);
      if (disturb && c == 2) begin
        start = 1'b1;
        value = 32'h000000FF;
      end
      if (disturb && c == 3) start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    check({tag, "_found"}, {31'b0, found}, {31'b0, exp_f});
    check({tag, "_so"}, {20'b0, shift_operand}, {20'b0, exp_so});
    if (found) begin
      dec = ror({24'b0, shift_operand[7:0]}, 2 * shift_operand[11:8]);
      check({tag, "_decode"}, dec, v);
    end
    pulses = (lat != 0) ? 1 : 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check({tag, "_pulses"}, pulses, 32'd1);
    check({tag, "_hold"}, {19'b0, found, shift_operand}, {19'b0, exp_f, exp_so});
  endtask

  int          m_lat;
  logic        m_f;
  logic [11:0] m_so;
  logic [31:0] rv;
  int          dones;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    value = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_found", {31'b0, found}, 32'd0);
    check("reset_so", {20'b0, shift_operand}, 32'd0);
    rst_n = 1'b1;

    run_vec("ff",       32'h000000FF, 2,  1'b1, 12'h0FF, 1'b0);
    run_vec("ff000000", 32'hFF000000, 6,  1'b1, 12'h4FF, 1'b0);
    run_vec("f000000f", 32'hF000000F, 4,  1'b1, 12'h2FF, 1'b0);
    run_vec("104",      32'h00000104, 17, 1'b1, 12'hF41, 1'b0);
    run_vec("101",      32'h00000101, 17, 1'b0, 12'h000, 1'b0);
    run_vec("zero",     32'h00000000, 2,  1'b1, 12'h000, 1'b0);
    run_vec("disturb",  32'hFF000000, 6,  1'b1, 12'h4FF, 1'b1);

    // Reset in the middle of a search: outputs clear at once and no done follows.
    @(negedge clk);
    value = 32'h00000101;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_found", {31'b0, found}, 32'd0);
    check("abort_so", {20'b0, shift_operand}, 32'd0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 32'd0);
    run_vec("post_reset", 32'h00000000, 2, 1'b1, 12'h000, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rv = $urandom;
      if (i % 2 == 0) rv = ror({24'b0, rv[7:0]}, 2 * int'(rv[11:8]));
      model(rv, m_lat, m_f, m_so);
      run_vec($sformatf("rand%0d", i), rv, m_lat, m_f, m_so, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
